// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rcv_state_t;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Synchronizer chain; both stages reset to the line's inactive value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rcv.sv
// 8N1 UART receiver: mid-bit sampling, LSB-first shift, stop-bit check, one-cycle result pulses.
module uart_rcv
  import uart_pkg::*;
#(
  parameter int unsigned WAIT_TIME = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd_in,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       active
);

  localparam int unsigned HALF  = WAIT_TIME / 2;
  localparam int unsigned CNT_W = $clog2(WAIT_TIME);
  localparam int unsigned IDX_W = 3;

  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(WAIT_TIME - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(UART_DATA_BITS - 1);

  logic rxd_s;
  logic rxd_d_q;

  rcv_state_t                state_q,     state_d;
  logic [CNT_W-1:0]          cnt_q,       cnt_d;
  logic [IDX_W-1:0]          idx_q,       idx_d;
  logic [UART_DATA_BITS-1:0] shift_q,     shift_d;
  logic [UART_DATA_BITS-1:0] data_q,      data_d;
  logic                      valid_q,     valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      active_q,    active_d;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (UART_IDLE_LEVEL)
  ) u_sync_rxd (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd_in),
    .q     (rxd_s)
  );

  // Delayed copy of the synchronized line for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_d_q <= UART_IDLE_LEVEL;
    end else begin
      rxd_d_q <= rxd_s;
    end
  end

  // Frame sequencing: start validation, data shifting, stop check.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    active_d    = active_q;

    case (state_q)
      IDLE: begin
        active_d = 1'b0;
        // A held-low line never restarts; a fresh high-to-low edge is needed.
        if (rxd_d_q && !rxd_s) begin
          state_d  = START;
          cnt_d    = '0;
          active_d = 1'b1;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF_END) begin
          if (!rxd_s) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          shift_d = {rxd_s, shift_q[UART_DATA_BITS-1:1]};
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        // Returning to IDLE mid-stop-bit lets back-to-back frames follow without loss.
        if (cnt_q == CNT_BIT_END) begin
          if (rxd_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d  = IDLE;
          active_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      active_q    <= active_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign active    = active_q;

endmodule

// File: tb/tb_uart_rcv.sv
// Testbench for uart_rcv: timing-formula reference model, per-cycle compare, directed and random frames.
module tb_uart_rcv;

  localparam int unsigned W    = 16;
  localparam int unsigned HALF = W / 2;
  localparam int          LAT  = 2 + HALF + 9 * W;  // first low sample edge to result edge

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rxd_in = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       active;

  uart_rcv #(.WAIT_TIME(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd_in    (rxd_in),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .active    (active)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Line value seen at each posedge (forced idle while in reset, as the synchronizer is).
  bit         lm [0:65535];
  bit         m_busy   = 1'b0;
  int         m_e      = 0;
  logic [7:0] m_shift  = 8'h00;
  logic [7:0] m_data   = 8'h00;
  logic       m_valid  = 1'b0;
  logic       m_ferr   = 1'b0;
  logic       m_active = 1'b0;

  // Reference model: the FSM sees the line two edges late; all sample points derive from E.
  always @(posedge clk) begin
    int rel;
    int n;
    cyc++;
    lm[cyc] = rst_n ? rxd_in : 1'b1;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    if (!rst_n) begin
      m_busy   = 1'b0;
      m_active = 1'b0;
      m_data   = 8'h00;
    end else if (!m_busy) begin
      if (cyc >= 4 && lm[cyc-3] && !lm[cyc-2]) begin
        m_busy   = 1'b1;
        m_e      = cyc;
        m_active = 1'b1;
      end
    end else begin
      rel = cyc - m_e;
      if (rel == HALF) begin
        if (lm[cyc-2]) begin
          m_busy   = 1'b0;
          m_active = 1'b0;
        end
      end else if (rel > HALF && ((rel - HALF) % W) == 0) begin
        n = (rel - HALF) / W;
        if (n <= 8) begin
          m_shift[n-1] = lm[cyc-2];
        end else begin
          if (lm[cyc-2]) begin
            m_valid = 1'b1;
            m_data  = m_shift;
          end else begin
            m_ferr = 1'b1;
          end
          m_busy   = 1'b0;
          m_active = 1'b0;
        end
      end
    end
  end

  int         n_valid        = 0;
  int         n_ferr         = 0;
  int         n_act          = 0;
  int         last_valid_cyc = -1;
  logic [7:0] got [$];

  // Per-cycle compare against the model, plus event counters for the directed checks.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
    end else begin
      chk("valid", 32'(valid), 32'(m_valid));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      chk("active", 32'(active), 32'(m_active));
      chk("data", 32'(data), 32'(m_data));
    end
    if (valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      got.push_back(data);
    end
    if (frame_err) n_ferr++;
    if (active) n_act++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rxd_in = 1'b1;
    end
  endtask

  task automatic hold_low(input int n);
    repeat (n) begin
      @(negedge clk);
      rxd_in = 1'b0;
    end
  endtask

  // per = bit period in 1/100 cycles; p = edge that first samples the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per,
                            input int max_t, output int p);
    logic [9:0] bits;
    int         nt;
    bits = {stop_bit, b, 1'b0};
    nt   = (10 * per) / 100;
    p    = 0;
    for (int t = 0; t < nt && t < max_t; t++) begin
      @(negedge clk);
      rxd_in = bits[(t * 100) / per];
      if (t == 0) p = cyc + 1;
    end
  endtask

  initial begin
    int p;
    int nv0;
    int nf0;
    int na0;

    // Reset with a toggling line.
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd_in = 1'($urandom_range(0, 1));
    end
    idle(3);
    rst_n = 1'b1;
    na0 = n_act;
    idle(20);
    chk("idle_after_reset_active", 32'(n_act - na0), 32'd0);
    chk("idle_after_reset_data", 32'(data), 32'h00);

    // Single good frame 0xA5.
    nv0 = n_valid; na0 = n_act;
    send_frame(8'hA5, 1'b1, 1600, 1000, p);
    idle(20);
    chk("a5_valid_count", 32'(n_valid - nv0), 32'd1);
    chk("a5_data", 32'(data), 32'hA5);
    chk("a5_latency", 32'(last_valid_cyc - p), 32'(LAT));
    chk("a5_active_cycles", 32'(n_act - na0), 32'(HALF + 9 * W));

    // Three-cycle glitch is a false start.
    nv0 = n_valid; nf0 = n_ferr; na0 = n_act;
    hold_low(3);
    idle(30);
    chk("glitch_active_cycles", 32'(n_act - na0), 32'(HALF));
    chk("glitch_valid", 32'(n_valid - nv0), 32'd0);
    chk("glitch_ferr", 32'(n_ferr - nf0), 32'd0);
    chk("glitch_data", 32'(data), 32'hA5);

    // Framing error, then a break that must not start a frame.
    nv0 = n_valid; nf0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1600, 1000, p);
    na0 = n_act;
    hold_low(100);
    chk("break_active", 32'(n_act - na0), 32'd0);
    chk("ferr_count", 32'(n_ferr - nf0), 32'd1);
    chk("ferr_valid", 32'(n_valid - nv0), 32'd0);
    chk("ferr_data_kept", 32'(data), 32'hA5);
    idle(20);

    // Back-to-back frames, last one from a 3% fast transmitter.
    got.delete();
    send_frame(8'h00, 1'b1, 1600, 1000, p);
    send_frame(8'hFF, 1'b1, 1600, 1000, p);
    send_frame(8'h81, 1'b1, 1553, 1000, p);
    idle(30);
    chk("b2b_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("b2b_byte0", 32'(got[0]), 32'h00);
      chk("b2b_byte1", 32'(got[1]), 32'hFF);
      chk("b2b_byte2", 32'(got[2]), 32'h81);
    end

    // Asynchronous reset after bit 4 of 0x5A.
    nv0 = n_valid;
    send_frame(8'h5A, 1'b1, 1600, 96, p);
    chk("pre_reset_active", 32'(active), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_active", 32'(active), 32'd0);
    chk("async_rst_data", 32'(data), 32'h00);
    rxd_in = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(20);
    chk("aborted_no_pulse", 32'(n_valid - nv0), 32'd0);
    send_frame(8'h5A, 1'b1, 1600, 1000, p);
    idle(20);
    chk("after_rst_valid", 32'(n_valid - nv0), 32'd1);
    chk("after_rst_data", 32'(data), 32'h5A);

    // Random frames, glitches, baud offsets and bad stop bits against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        hold_low(int'($urandom_range(1, 6)));
        idle(int'($urandom_range(20, 40)));
      end else begin
        send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0),
                   int'($urandom_range(1560, 1640)), 1000, p);
        idle(int'($urandom_range(0, 12)));
      end
    end
    idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rcv.md
# uart_rcv

UART receiver for 8N1 serial frames: oversamples an asynchronous serial line at the system clock, validates the start bit, shifts in eight data bits LSB first, checks the stop bit, and presents the byte with a one-cycle valid pulse. It terminates the serial link opposite the team's UART transmitter and feeds byte-oriented consumers (command parsers, FIFOs) that take data without backpressure.

## Interface
- WAIT_TIME, 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range ≥ 4.
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- rxd_in  input  1  serial line, asynchronous to clk, idle high.
- data  output  8  last correctly framed byte; holds until the next good frame.
- valid  output  1  one-cycle pulse: data was updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low; data not updated.
- active  output  1  high while a frame is being received (START through STOP).

## Operation
- rxd_in passes through a 2-flop synchronizer (both flops reset to 1) giving rxd_s; one extra registered copy rxd_d detects falling edges.
- HALF = WAIT_TIME/2 (floor). Bit counter cnt is $clog2(WAIT_TIME) bits wide; index idx is 3 bits.
- States: IDLE, START, DATA, STOP.
- IDLE: active=0. On rxd_d==1 && rxd_s==0 → START, cnt=0, active=1. A line that stays low (break) never triggers a start; a new high-to-low edge is required.
- START: when cnt==HALF-1, sample rxd_s: 0 → DATA, cnt=0, idx=0; 1 → false start, back to IDLE, active=0, no pulses. Otherwise cnt++.
- DATA: when cnt==WAIT_TIME-1, shift rxd_s into MSB of shift register (right shift, so bit 0 lands in LSB after 8 samples), cnt=0; idx==7 → STOP, else idx++. Otherwise cnt++.
- STOP: when cnt==WAIT_TIME-1, sample rxd_s: 1 → data<=shift, valid=1; 0 → frame_err=1, data unchanged. Either way → IDLE, active=0. Otherwise cnt++.
- valid and frame_err never assert together; both deassert the cycle after assertion.
- No overrun detection: consumer must accept data in the valid cycle.
- Reset asserted mid-frame aborts immediately; the frame is discarded with no pulse.

## Timing
- Reset values: data=8'h00, valid=0, frame_err=0, active=0, state=IDLE, cnt=0, idx=0, sync flops=1.
- Let E be the clk edge where FSM leaves IDLE (2–3 cycles after the physical falling edge on rxd_in).
- Start validated at E+HALF; data bit i sampled at E+HALF+(i+1)·WAIT_TIME; stop sampled at E+HALF+9·WAIT_TIME.
- valid / frame_err / active-fall visible in the cycle following the stop-sampling edge.
- FSM is back in IDLE mid-stop-bit, so back-to-back frames with a full 1-bit stop are received without loss; the next start edge is detectable from the following cycle.
- Tolerates ±~4% aggregate baud mismatch with mid-bit sampling.

## Structure
- Shared package uart_pkg: state enum rcv_state_t {IDLE, START, DATA, STOP} (logic [1:0]), constants UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1, also used by the transmitter.
- One sub-module: sync_2ff (parameterised width, reset value), reused for other asynchronous inputs.
- Counter width derived from WAIT_TIME.

## Test plan
- Reset: hold rst_n low, toggle rxd_in → data=0x00, valid=0, frame_err=0, active=0 throughout; release with line idle → stays IDLE.
- WAIT_TIME=16, frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → single valid pulse, data=0xA5, active high from E to pulse, at the cycle predicted above.
- Glitch: rxd_in low 3 cycles then high, WAIT_TIME=16 → active rises, falls at E+8, no valid/frame_err, data unchanged.
- Framing error: 0x3C with stop bit low → frame_err one cycle, valid=0, data keeps prior 0xA5; line held low afterward → no new start until high-then-low.
- Back-to-back 0x00 then 0xFF, 1-bit stop, then 0x81 with transmitter baud +3% → three valid pulses, data 0x00, 0xFF, 0x81 in order.
- Async reset mid-DATA (after bit 4 of 0x5A) → active=0 immediately without clock; after release, next full frame 0x5A received correctly; aborted frame never produces a pulse.
